writeback_sequencer: RTL and testbench
======================================

// Module: writeback_sequencer
// PURPOSE
//  Controller for the register-file writeback mux of the 8-bit micro. Takes a decoded
//  writeback request (source op + destination register), drives the mux select, handles
//  the external data-bus read handshake for bus loads, and issues one register write strobe.
//  Sits between the decoder and the writeback mux / register file.
// PARAMETERS
//  TIMEOUT_CYCLES  15  BUS_WAIT cycles without i_BusAck before abort (only with WB_TIMEOUT_EN)
//  CNT_W           8   width of o_WbCount
// PORTS
//  i_Clk        in   1      system clock, rising edge
//  i_Rst_n      in   1      asynchronous reset, active-low
//  i_Start      in   1      request strobe; sampled only when o_Busy=0
//  i_Op         in   3      source: 000 bus, 010 RY, 011 RX, 100 Num, 101 SaveR7
//  i_DstReg     in   3      destination register index
//  i_BusAck     in   1      bus slave ack; data valid on bus the cycle after ack
//  o_Busy       out  1      1 in any state other than IDLE
//  o_BusReq     out  1      bus read request, high in BUS_WAIT only
//  o_Sel_Mux    out  3      writeback mux select
//  o_RegWe      out  1      register write strobe, one cycle
//  o_RegAddr    out  3      write address (latched i_DstReg)
//  o_Done       out  1      one-cycle pulse, same cycle as o_RegWe
//  o_Err        out  1      one-cycle pulse on invalid op or bus timeout
//  o_WbCount    out  CNT_W  count of completed writes
// BEHAVIOUR
//  Reset (async, i_Rst_n=0): state=IDLE; o_Busy=0, o_BusReq=0, o_Sel_Mux=3'b111,
//   o_RegWe=0, o_RegAddr=0, o_Done=0, o_Err=0, o_WbCount=0; op/dst latches cleared.
//  All outputs are Moore-decoded from registered state and latches; no comb path in->out.
//  FSM states: IDLE, BUS_WAIT, WRITE, ERR.
//   IDLE: o_Sel_Mux=3'b111 (mux outputs 0). i_Start=1 -> latch i_Op and i_DstReg, then:
//     op=000 -> BUS_WAIT; op in {010,011,100,101} -> WRITE; op in {001,110,111} -> ERR.
//   BUS_WAIT: o_BusReq=1, o_Sel_Mux=000. i_BusAck=1 sampled -> WRITE; else stay.
//   WRITE: o_RegWe=1, o_Done=1, o_Sel_Mux=latched op, o_RegAddr=latched dst;
//     o_WbCount increments; -> IDLE.
//   ERR: o_Err=1, o_RegWe=0, count unchanged; -> IDLE.
//  Latency: register op: start edge N -> o_RegWe high in cycle N+1, idle at N+2.
//   Bus op: o_RegWe in cycle after the edge that samples i_BusAck.
//  Boundary rules:
//   - i_Start while o_Busy=1 ignored (no queueing, latches unchanged).
//   - i_BusAck outside BUS_WAIT ignored.
//   - i_Start in the WRITE/ERR return cycle ignored; accepted from next IDLE cycle.
//   - o_WbCount wraps 2^CNT_W-1 -> 0 with no flag.
//   - reset mid-operation: immediate return to IDLE, no write strobe, no Done/Err.
//   - back-to-back requests: max rate one register op every 2 cycles.
// CONFIGURATION
//  WB_TIMEOUT_EN defined: cycle counter runs in BUS_WAIT (cleared on entry); after
//   TIMEOUT_CYCLES cycles with no ack -> ERR (o_BusReq drops, no write). Ack in the
//   same cycle the limit is reached wins -> WRITE.
//  WB_TIMEOUT_EN undefined: no counter; BUS_WAIT waits indefinitely for i_BusAck.
// TESTING
//  1 Reset with i_Rst_n=0 mid-BUS_WAIT -> all outputs at reset values, o_RegWe never high.
//  2 Start op=011 dst=5 -> next cycle o_RegWe=1, Sel=011, Addr=5, Done=1; o_WbCount 0->1.
//  3 Start op=000 dst=2, ack after 4 cycles -> BusReq high 4+1 cycles, then RegWe, Sel=000, Addr=2.
//  4 Start op=110 -> o_Err pulse 1 cycle, no RegWe, o_WbCount unchanged; i_Start during busy ignored.
//  5 WB_TIMEOUT_EN, op=000, no ack -> o_Err after 15 BUS_WAIT cycles, BusReq low; without macro stays waiting.
//  6 256 back-to-back op=100 writes -> o_WbCount wraps to 0; each write spaced 2 cycles.

Source files
------------

// File: rtl/writeback_sequencer.sv
// Writeback controller: selects the writeback mux source, runs the bus-load handshake and
// issues one register write strobe. Optional bus timeout enabled by defining WB_TIMEOUT_EN.
module writeback_sequencer #(
`ifdef WB_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 15,
`endif
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Start,
    input  logic [2:0]       i_Op,
    input  logic [2:0]       i_DstReg,
    input  logic             i_BusAck,
    output logic             o_Busy,
    output logic             o_BusReq,
    output logic [2:0]       o_Sel_Mux,
    output logic             o_RegWe,
    output logic [2:0]       o_RegAddr,
    output logic             o_Done,
    output logic             o_Err,
    output logic [CNT_W-1:0] o_WbCount
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StBusWait = 2'd1;
    localparam logic [1:0] StWrite   = 2'd2;
    localparam logic [1:0] StErr     = 2'd3;

    // Mux select that forces the writeback data to zero.
    localparam logic [2:0] SelZero = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       dst_q, dst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
`ifdef WB_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
`endif
        case (state_q)
            StIdle: begin
`ifdef WB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (i_Start) begin
                    op_d  = i_Op;
                    dst_d = i_DstReg;
                    case (i_Op)
                        3'b000:                         state_d = StBusWait;
                        3'b010, 3'b011, 3'b100, 3'b101: state_d = StWrite;
                        default:                        state_d = StErr;
                    endcase
                end
            end
            StBusWait: begin
                if (i_BusAck) begin
                    state_d = StWrite;
`ifdef WB_TIMEOUT_EN
                end else if (to_cnt_q == ToLast) begin
                    state_d = StErr;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            StWrite: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // Outputs depend only on registered state, never directly on inputs.
    always_comb begin
        o_Busy    = (state_q != StIdle);
        o_BusReq  = (state_q == StBusWait);
        o_RegWe   = (state_q == StWrite);
        o_Done    = (state_q == StWrite);
        o_Err     = (state_q == StErr);
        o_RegAddr = dst_q;
        o_WbCount = cnt_q;
        case (state_q)
            StBusWait: o_Sel_Mux = 3'b000;
            StWrite:   o_Sel_Mux = op_q;
            default:   o_Sel_Mux = SelZero;
        endcase
    end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed, table-driven bench for writeback_sequencer.
module tb_writeback_sequencer;

    logic       i_Clk = 1'b0;
    logic       i_Rst_n;
    logic       i_Start;
    logic [2:0] i_Op;
    logic [2:0] i_DstReg;
    logic       i_BusAck;
    logic       o_Busy;
    logic       o_BusReq;
    logic [2:0] o_Sel_Mux;
    logic       o_RegWe;
    logic [2:0] o_RegAddr;
    logic       o_Done;
    logic       o_Err;
    logic [7:0] o_WbCount;

    writeback_sequencer dut (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .i_Start   (i_Start),
        .i_Op      (i_Op),
        .i_DstReg  (i_DstReg),
        .i_BusAck  (i_BusAck),
        .o_Busy    (o_Busy),
        .o_BusReq  (o_BusReq),
        .o_Sel_Mux (o_Sel_Mux),
        .o_RegWe   (o_RegWe),
        .o_RegAddr (o_RegAddr),
        .o_Done    (o_Done),
        .o_Err     (o_Err),
        .o_WbCount (o_WbCount)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [2:0] op;
        logic [2:0] dst;
        logic       exp_we;
        logic       exp_err;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t       vecs[8];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cnt  = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},   32'(o_Busy),    0);
        check({tag, "_busreq"}, 32'(o_BusReq),  0);
        check({tag, "_sel"},    32'(o_Sel_Mux), 7);
        check({tag, "_regwe"},  32'(o_RegWe),   0);
        check({tag, "_addr"},   32'(o_RegAddr), 0);
        check({tag, "_done"},   32'(o_Done),    0);
        check({tag, "_err"},    32'(o_Err),     0);
        check({tag, "_count"},  32'(o_WbCount), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{op: 3'b011, dst: 3'd5, exp_we: 1'b1, exp_err: 1'b0, exp_sel: 3'b011};
        vecs[1] = '{op: 3'b010, dst: 3'd1, exp_we: 1'b1, exp_err: 1'b0, exp_sel: 3'b010};
        vecs[2] = '{op: 3'b100, dst: 3'd7, exp_we: 1'b1, exp_err: 1'b0, exp_sel: 3'b100};
        vecs[3] = '{op: 3'b101, dst: 3'd0, exp_we: 1'b1, exp_err: 1'b0, exp_sel: 3'b101};
        vecs[4] = '{op: 3'b001, dst: 3'd4, exp_we: 1'b0, exp_err: 1'b1, exp_sel: 3'b111};
        vecs[5] = '{op: 3'b110, dst: 3'd3, exp_we: 1'b0, exp_err: 1'b1, exp_sel: 3'b111};
        vecs[6] = '{op: 3'b111, dst: 3'd6, exp_we: 1'b0, exp_err: 1'b1, exp_sel: 3'b111};
        vecs[7] = '{op: 3'b011, dst: 3'd2, exp_we: 1'b1, exp_err: 1'b0, exp_sel: 3'b011};

        i_Rst_n  = 1'b0;
        i_Start  = 1'b0;
        i_Op     = 3'b000;
        i_DstReg = 3'd0;
        i_BusAck = 1'b0;
        #1;
        check_reset_vals("por");
        tick();
        tick();
        i_Rst_n = 1'b1;
        tick();

        // Reset asserted in the middle of a bus wait.
        i_Start  = 1'b1;
        i_Op     = 3'b000;
        i_DstReg = 3'd4;
        tick();
        i_Start = 1'b0;
        check("rst_mid_busreq", 32'(o_BusReq), 1);
        tick();
        i_Rst_n  = 1'b0;
        i_BusAck = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_hold_regwe", 32'(o_RegWe), 0);
        end
        i_Rst_n  = 1'b1;
        i_BusAck = 1'b0;
        tick();
        check("rst_rel_regwe", 32'(o_RegWe), 0);
        check("rst_rel_busy",  32'(o_Busy),  0);

        // Register ops and invalid ops from the table; ack toggled to show it is ignored.
        for (int i = 0; i < 8; i++) begin
            i_Start  = 1'b1;
            i_Op     = vecs[i].op;
            i_DstReg = vecs[i].dst;
            i_BusAck = 1'(i % 2);
            tick();
            i_Start  = 1'b0;
            i_Op     = 3'b001;
            i_DstReg = ~vecs[i].dst;
            check("vec_busy",   32'(o_Busy),    1);
            check("vec_regwe",  32'(o_RegWe),   32'(vecs[i].exp_we));
            check("vec_done",   32'(o_Done),    32'(vecs[i].exp_we));
            check("vec_err",    32'(o_Err),     32'(vecs[i].exp_err));
            check("vec_sel",    32'(o_Sel_Mux), 32'(vecs[i].exp_sel));
            check("vec_addr",   32'(o_RegAddr), 32'(vecs[i].dst));
            check("vec_busreq", 32'(o_BusReq),  0);
            check("vec_cnt_pre", 32'(o_WbCount), 32'(exp_cnt));
            tick();
            if (vecs[i].exp_we) exp_cnt++;
            check("vec_idle_busy", 32'(o_Busy),    0);
            check("vec_idle_we",   32'(o_RegWe),   0);
            check("vec_idle_err",  32'(o_Err),     0);
            check("vec_idle_sel",  32'(o_Sel_Mux), 7);
            check("vec_idle_addr", 32'(o_RegAddr), 32'(vecs[i].dst));
            check("vec_cnt",       32'(o_WbCount), 32'(exp_cnt));
        end
        i_BusAck = 1'b0;

        // Start during ERR is dropped; held start is taken from the next idle cycle.
        i_Start  = 1'b1;
        i_Op     = 3'b110;
        i_DstReg = 3'd3;
        tick();
        i_Op     = 3'b011;
        i_DstReg = 3'd6;
        check("err_pulse", 32'(o_Err),   1);
        check("err_regwe", 32'(o_RegWe), 0);
        tick();
        check("err_ret_idle", 32'(o_Busy),    0);
        check("err_ret_err",  32'(o_Err),     0);
        check("err_ret_addr", 32'(o_RegAddr), 3);
        check("err_ret_cnt",  32'(o_WbCount), 32'(exp_cnt));
        tick();
        i_Start = 1'b0;
        check("after_err_we",   32'(o_RegWe),   1);
        check("after_err_addr", 32'(o_RegAddr), 6);
        tick();
        exp_cnt++;
        check("after_err_cnt", 32'(o_WbCount), 32'(exp_cnt));

        // Bus load, ack on the fifth wait cycle; start during the wait is ignored.
        i_Start  = 1'b1;
        i_Op     = 3'b000;
        i_DstReg = 3'd2;
        tick();
        n = 0;
        for (int k = 0; k < 4; k++) begin
            i_Start  = (k == 1);
            i_Op     = 3'b011;
            i_DstReg = 3'd7;
            if (o_BusReq) n++;
            check("bus_sel_wait", 32'(o_Sel_Mux), 0);
            tick();
        end
        i_Start = 1'b0;
        if (o_BusReq) n++;
        check("bus_req_cycles", 32'(n), 5);
        check("bus_wait_we",    32'(o_RegWe), 0);
        i_BusAck = 1'b1;
        tick();
        i_BusAck = 1'b0;
        check("bus_we",     32'(o_RegWe),   1);
        check("bus_done",   32'(o_Done),    1);
        check("bus_sel",    32'(o_Sel_Mux), 0);
        check("bus_addr",   32'(o_RegAddr), 2);
        check("bus_req_off", 32'(o_BusReq), 0);
        tick();
        exp_cnt++;
        check("bus_cnt",  32'(o_WbCount), 32'(exp_cnt));
        check("bus_idle", 32'(o_Busy),    0);

        // Bus load with no ack.
        i_Start  = 1'b1;
        i_Op     = 3'b000;
        i_DstReg = 3'd1;
        tick();
        i_Start = 1'b0;
`ifdef WB_TIMEOUT_EN
        n = 0;
        while (o_BusReq && n < 40) begin
            n++;
            tick();
        end
        check("to_len",    32'(n),        15);
        check("to_err",    32'(o_Err),    1);
        check("to_busreq", 32'(o_BusReq), 0);
        check("to_regwe",  32'(o_RegWe),  0);
        tick();
        check("to_err_off", 32'(o_Err),     0);
        check("to_cnt",     32'(o_WbCount), 32'(exp_cnt));
`else
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_BusReq && !o_Err) n++;
            tick();
        end
        check("nto_wait", 32'(n), 20);
        i_BusAck = 1'b1;
        tick();
        i_BusAck = 1'b0;
        check("nto_we", 32'(o_RegWe), 1);
        tick();
        exp_cnt++;
        check("nto_cnt", 32'(o_WbCount), 32'(exp_cnt));
`endif

        // 256 back-to-back writes from a cleared counter; start held high throughout.
        i_Rst_n = 1'b0;
        tick();
        i_Rst_n = 1'b1;
        exp_cnt = 8'd0;
        i_Start  = 1'b1;
        i_Op     = 3'b100;
        i_DstReg = 3'd1;
        for (int w = 0; w < 256; w++) begin
            tick();
            check("b2b_we", 32'(o_RegWe), 1);
            tick();
            exp_cnt++;
            check("b2b_gap", 32'(o_RegWe), 0);
            check("b2b_cnt", 32'(o_WbCount), 32'(exp_cnt));
            if (w == 254) check("b2b_max", 32'(o_WbCount), 255);
        end
        i_Start = 1'b0;
        check("b2b_wrap", 32'(o_WbCount), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
